// File: rtl/instr_mem_loader.sv
// Write-side loader for the byte-organised instruction memory: takes 32-bit words
// from a valid/ready stream and writes them little-endian, one byte per cycle.
module instr_mem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_overflow
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  // One extra address bit so the pointer can sit at MEM_BYTES without wrapping to 0.
  localparam logic [ADDR_W:0] LAST_FIT = (ADDR_W+1)'(MEM_BYTES - 4);

  state_t          state_q, state_d;
  logic [ADDR_W:0] wr_addr_q, wr_addr_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     word_q, word_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic            fit;
  logic            unused_base_lsb;

  assign unused_base_lsb = ^base_addr[1:0];
  assign fit = (wr_addr_q <= LAST_FIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      byte_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_addr_q <= wr_addr_d;
    word_q    <= word_d;
    last_q    <= last_d;
  end

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    last_d     = last_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          wr_addr_d = {1'b0, base_addr[ADDR_W-1:2], 2'b00};
          err_d     = 1'b0;
          state_d   = ACCEPT;
        end
      end
      ACCEPT: begin
        if (s_valid) begin
          if (fit) begin
            word_d     = s_data;
            last_d     = s_last;
            byte_idx_d = 2'd0;
            state_d    = WRITE;
          end else begin
            // Word is consumed but dropped; a partial word is never written.
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        wr_addr_d  = wr_addr_q + 1'b1;
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          state_d = last_q ? DONE : ACCEPT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_ready      = (state_q == ACCEPT);
  assign mem_we       = (state_q == WRITE);
  assign mem_addr     = mem_we ? wr_addr_q[ADDR_W-1:0] : '0;
  assign mem_wdata    = mem_we ? word_q[{byte_idx_q, 3'b000} +: 8] : 8'h00;
  assign busy         = (state_q != IDLE);
  assign cpu_hold     = busy;
  assign done         = (state_q == DONE);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: byte writes are logged on the falling edge
// and each scenario task compares them with hand-computed values.
module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       rst, start, s_valid, s_last;
  logic [9:0] base_addr;
  logic [31:0] s_data;
  logic       s_ready, mem_we, busy, cpu_hold, done, err_overflow;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rdy_viol = 0;
  logic [9:0] q_addr[$];
  logic [7:0] q_data[$];
  int         q_cyc[$];

  instr_mem_loader #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_wdata);
      q_cyc.push_back(cyc);
      if (s_ready) rdy_viol++;
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    done_cnt = 0;
    rdy_viol = 0;
  endtask

  task automatic do_start(input logic [9:0] base);
    start = 1'b1;
    base_addr = base;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    bit taken = 0;
    s_valid = 1'b1;
    s_data = data;
    s_last = last;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_ready) begin
        taken = 1;
        break;
      end
    end
    step();
    s_valid = 1'b0;
    s_last = 1'b0;
    checks++;
    if (!taken) begin
      failures++;
      $display("FAIL handshake_timeout word=%h s_ready never seen high", data);
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout done pulse not seen within 100 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    step(); step();
    @(negedge clk);
    checks++;
    if ({s_ready, mem_we, busy, cpu_hold, done, err_overflow} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000", {s_ready, mem_we, busy, cpu_hold, done, err_overflow});
    end
    checks++;
    if (mem_addr !== 10'd0 || mem_wdata !== 8'd0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
    end
    step();
    rst = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_valid_ignored s_ready=%b busy=%b want 0/0", s_ready, busy);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic test_single_word();
    logic [9:0] ea [4] = '{10'd0, 10'd1, 10'd2, 10'd3};
    logic [7:0] ed [4] = '{8'h13, 8'h84, 8'h50, 8'h00};
    clear_log();
    do_start(10'd0);
    send_word(32'h00508413, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd0) begin
      failures++;
      $display("FAIL first_write_latency mem_we=%b addr=%h want 1/000", mem_we, mem_addr);
    end
    wait_done();
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_done busy=%b hold=%b want 1/1", busy, cpu_hold);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL after_done busy=%b hold=%b done=%b want 0/0/0", busy, cpu_hold, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || q_addr.size() !== 4) begin
      failures++;
      $display("FAIL single_counts done=%0d writes=%0d want 1/4", done_cnt, q_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_addr.size() || q_addr[i] !== ea[i] || q_data[i] !== ed[i]) begin
        failures++;
        $display("FAIL single_byte%0d got=(%h,%h) want=(%h,%h)", i, q_addr[i], q_data[i], ea[i], ed[i]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed [8] = '{8'h33, 8'h84, 8'h20, 8'h00, 8'h93, 8'h00, 8'h40, 8'h06};
    clear_log();
    do_start(10'h010);
    send_word(32'h00208433, 1'b0);
    repeat (8) step();
    send_word(32'h06400093, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    checks++;
    if (q_addr.size() !== 8 || done_cnt !== 1) begin
      failures++;
      $display("FAIL multi_counts writes=%0d done=%0d want 8/1", q_addr.size(), done_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= q_addr.size() || q_addr[i] !== 10'(16 + i) || q_data[i] !== ed[i]) begin
        failures++;
        $display("FAIL multi_byte%0d got=(%h,%h) want=(%h,%h)", i, q_addr[i], q_data[i], 10'(16 + i), ed[i]);
      end
    end
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (q_cyc.size() < 8 || q_cyc[4*w+3] - q_cyc[4*w] !== 3) begin
        failures++;
        $display("FAIL multi_gap word%0d span=%0d want 3", w, (q_cyc.size() < 8) ? -1 : q_cyc[4*w+3] - q_cyc[4*w]);
      end
    end
    checks++;
    if (rdy_viol !== 0) begin
      failures++;
      $display("FAIL ready_in_write count=%0d want 0", rdy_viol);
    end
    step();
  endtask

  task automatic test_misaligned();
    clear_log();
    do_start(10'h007);
    send_word(32'hAABBCCDD, 1'b1);
    wait_done();
    @(negedge clk);
    checks++;
    if (q_addr.size() !== 4 || q_addr[0] !== 10'd4 || q_data[0] !== 8'hDD || q_addr[3] !== 10'd7 || q_data[3] !== 8'hAA) begin
      failures++;
      $display("FAIL misaligned first=(%h,%h) last=(%h,%h) want (004,dd) (007,aa)", q_addr[0], q_data[0], q_addr[3], q_data[3]);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [7:0] ed [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    clear_log();
    do_start(10'h3FC);
    send_word(32'h11223344, 1'b0);
    send_word(32'h55667788, 1'b1);
    wait_done();
    checks++;
    if (err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_flag got=%b want=1", err_overflow);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q_addr.size() !== 4 || err_overflow !== 1'b1 || done_cnt !== 1) begin
      failures++;
      $display("FAIL overflow_counts writes=%0d err=%b done=%0d want 4/1/1", q_addr.size(), err_overflow, done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_addr.size() || q_addr[i] !== 10'(12'h3FC + i) || q_data[i] !== ed[i]) begin
        failures++;
        $display("FAIL overflow_byte%0d got=(%h,%h) want=(%h,%h)", i, q_addr[i], q_data[i], 10'(12'h3FC + i), ed[i]);
      end
    end
    step();
    do_start(10'h020);
    @(negedge clk);
    checks++;
    if (err_overflow !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL overflow_clear err=%b s_ready=%b want 0/1", err_overflow, s_ready);
    end
    step();
    send_word(32'h00000013, 1'b1);
    wait_done();
    checks++;
    if (err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_stays_clear got=%b want=0", err_overflow);
    end
    step();
  endtask

  task automatic test_reset_mid_word();
    clear_log();
    do_start(10'h040);
    send_word(32'hCAFEF00D, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state we=%b busy=%b done=%b rdy=%b want 0/0/0/0", mem_we, busy, done, s_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_done done=%0d busy=%b want 0/0", done_cnt, busy);
    end
    checks++;
    if (q_addr.size() < 2 || q_addr[0] !== 10'h040 || q_data[0] !== 8'h0D || q_addr[1] !== 10'h041 || q_data[1] !== 8'hF0) begin
      failures++;
      $display("FAIL midreset_bytes b0=(%h,%h) b1=(%h,%h) want (040,0d) (041,f0)", q_addr[0], q_data[0], q_addr[1], q_data[1]);
    end
    checks++;
    if (q_addr.size() > 3) begin
      failures++;
      $display("FAIL midreset_extra_writes got=%0d want<=3", q_addr.size());
    end
    step();
  endtask

  task automatic test_ignored_start();
    logic [7:0] ed [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
    clear_log();
    do_start(10'h080);
    send_word(32'h01020304, 1'b1);
    start = 1'b1;
    base_addr = 10'h200;
    step();
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    checks++;
    if (q_addr.size() !== 4 || done_cnt !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignstart_counts writes=%0d done=%0d busy=%b want 4/1/0", q_addr.size(), done_cnt, busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_addr.size() || q_addr[i] !== 10'(12'h080 + i) || q_data[i] !== ed[i]) begin
        failures++;
        $display("FAIL ignstart_byte%0d got=(%h,%h) want=(%h,%h)", i, q_addr[i], q_data[i], 10'(12'h080 + i), ed[i]);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_misaligned();
    test_overflow();
    test_reset_mid_word();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
